// File: rtl/pipeline_step_ctrl.sv
// ============================================================================
//  Module   : pipeline_step_ctrl
//  Purpose  : Debug-unit execution controller for the MIPS pipeline. Produces
//             the pipeline-wide clock enable for RUN / STEP / RUN_N commands,
//             merges hazard stall and branch flush requests into the PC and
//             IF/ID controls, and (optionally) drains and halts the pipeline
//             when a HALT word reaches ID.
//  Config   : `define STEP_CTRL_HALT_DETECT_EN to build HALT detection,
//             DRAIN and HALTED. Without it i_instr is ignored, o_halted is 0
//             and RUN continues until ABORT.
//  Ports    : i_clk, i_reset         clock, synchronous active-high reset
//             i_cmd_valid/i_cmd      command strobe / opcode (RUN, STEP,
//             i_cmd_count            RUN_N, ABORT) and RUN_N cycle count
//             o_cmd_ready/o_cmd_err  handshake ready, ignored-command pulse
//             i_instr                instruction currently in ID
//             i_hazard_stall         load-use stall request
//             i_branch_flush         IF/ID flush request
//             o_dunit_clk_en         pipeline clock enable
//             o_pc_write             PC update enable
//             o_if_id_write/flush    IF/ID write enable / flush
//             o_busy, o_halted       status
//             o_cycle_count          saturating count of enabled cycles
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_step_ctrl #(
    parameter int                NB_REG       = 32,
    parameter int                NB_CNT       = 32,
    parameter logic [NB_REG-1:0] HALT_WORD    = {NB_REG{1'b1}},
    parameter int                DRAIN_CYCLES = 3
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cmd_valid,
    input  logic [1:0]        i_cmd,
    input  logic [NB_CNT-1:0] i_cmd_count,
    output logic              o_cmd_ready,
    output logic              o_cmd_err,
    input  logic [NB_REG-1:0] i_instr,
    input  logic              i_hazard_stall,
    input  logic              i_branch_flush,
    output logic              o_dunit_clk_en,
    output logic              o_pc_write,
    output logic              o_if_id_write,
    output logic              o_if_id_flush,
    output logic              o_busy,
    output logic              o_halted,
    output logic [NB_CNT-1:0] o_cycle_count
);

    localparam logic [1:0] c_CMD_RUN   = 2'b00;
    localparam logic [1:0] c_CMD_STEP  = 2'b01;
    localparam logic [1:0] c_CMD_RUN_N = 2'b10;
    localparam logic [1:0] c_CMD_ABORT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_COUNT  = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_HALTED = 3'd5
    } state_e;

    state_e            state_q, state_d;
    // Shared down-counter: RUN_N cycles left in COUNT, drain cycles left in DRAIN.
    logic [NB_CNT-1:0] remain_q, remain_d;
    logic              cmd_err_q, cmd_err_d;
    logic [NB_CNT-1:0] cycle_cnt_q;

    logic w_clk_en;
    logic w_cmd_ready;
    logic w_accept;
    logic w_halt_det;

    assign w_clk_en    = (state_q == ST_RUN)   || (state_q == ST_STEP) ||
                         (state_q == ST_COUNT) || (state_q == ST_DRAIN);
    assign w_cmd_ready = (state_q == ST_IDLE)  || (state_q == ST_RUN) ||
                         (state_q == ST_COUNT) || (state_q == ST_HALTED);
    assign w_accept    = i_cmd_valid & w_cmd_ready;

`ifdef STEP_CTRL_HALT_DETECT_EN
    assign w_halt_det  = w_clk_en && (state_q != ST_DRAIN) && (i_instr == HALT_WORD);
`else
    logic w_unused_instr;
    assign w_unused_instr = (i_instr == HALT_WORD);
    assign w_halt_det     = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        remain_d  = remain_q;
        cmd_err_d = 1'b0;

        if (w_halt_det) begin
            // HALT wins over STEP/COUNT completion and any same-cycle command.
            if (DRAIN_CYCLES == 0) begin
                state_d = ST_HALTED;
            end else begin
                state_d = ST_DRAIN;
            end
            remain_d = NB_CNT'(DRAIN_CYCLES);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_accept) begin
                        case (i_cmd)
                            c_CMD_RUN:  state_d = ST_RUN;
                            c_CMD_STEP: state_d = ST_STEP;
                            c_CMD_RUN_N: begin
                                if (i_cmd_count != '0) begin
                                    state_d  = ST_COUNT;
                                    remain_d = i_cmd_count;
                                end else begin
                                    cmd_err_d = 1'b1;
                                end
                            end
                            default: cmd_err_d = 1'b1;
                        endcase
                    end
                end
                ST_RUN, ST_HALTED: begin
                    if (w_accept) begin
                        if (i_cmd == c_CMD_ABORT) begin
                            state_d = ST_IDLE;
                        end else begin
                            cmd_err_d = 1'b1;
                        end
                    end
                end
                ST_STEP: begin
                    state_d = ST_IDLE;
                end
                ST_COUNT: begin
                    if (remain_q == NB_CNT'(1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        remain_d = remain_q - NB_CNT'(1);
                    end
                    if (w_accept) begin
                        if (i_cmd == c_CMD_ABORT) begin
                            state_d = ST_IDLE;
                        end else begin
                            cmd_err_d = 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (remain_q <= NB_CNT'(1)) begin
                        state_d = ST_HALTED;
                    end else begin
                        remain_d = remain_q - NB_CNT'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State and counters
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            remain_q    <= '0;
            cmd_err_q   <= 1'b0;
            cycle_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            remain_q  <= remain_d;
            cmd_err_q <= cmd_err_d;
            if (w_clk_en && (cycle_cnt_q != {NB_CNT{1'b1}})) begin
                cycle_cnt_q <= cycle_cnt_q + NB_CNT'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Pipeline control outputs
    // ------------------------------------------------------------------
    always_comb begin
        o_pc_write    = 1'b0;
        o_if_id_write = 1'b0;
        o_if_id_flush = 1'b0;
        if (w_clk_en) begin
            if (w_halt_det || (state_q == ST_DRAIN)) begin
                // Freeze fetch and bubble ID while older instructions retire.
                o_if_id_flush = 1'b1;
            end else begin
                o_pc_write    = ~i_hazard_stall;
                o_if_id_write = ~i_hazard_stall;
                o_if_id_flush = i_branch_flush;
            end
        end
    end

    assign o_dunit_clk_en = w_clk_en;
    assign o_busy         = w_clk_en;
    assign o_cmd_ready    = w_cmd_ready;
    assign o_cmd_err      = cmd_err_q;
    assign o_cycle_count  = cycle_cnt_q;

`ifdef STEP_CTRL_HALT_DETECT_EN
    assign o_halted = (state_q == ST_HALTED);
`else
    assign o_halted = 1'b0;
`endif

endmodule

`default_nettype wire
